// File: rtl/m_cache_refill_controller.sv
// Blocking read-refill controller for a 32-line direct-mapped cache of two-word lines.
// A lookup miss fetches both words of the line from memory, writes the line, then re-looks it up.
module m_cache_refill_controller (
  input  logic        w_clock,
  input  logic        w_rst_n,
  input  logic        w_req,
  input  logic [31:0] w_addr,
  output logic        w_ready,
  output logic        w_rvalid,
  output logic [31:0] w_rdata,
  output logic [31:0] w_c_addr,
  input  logic        w_c_hit,
  input  logic [31:0] w_c_dout,
  output logic        w_c_we,
  output logic [4:0]  w_c_wa,
  output logic [88:0] w_c_wd,
  output logic        w_mem_req,
  output logic [31:0] w_mem_addr,
  input  logic        w_mem_ack,
  input  logic [31:0] w_mem_data,
  output logic [15:0] w_hit_cnt,
  output logic [15:0] w_miss_cnt
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_FILL0,
    ST_FILL1,
    ST_WRITE
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   a_q;
  logic [DATA_W-1:0]   word0_q;
  logic [DATA_W-1:0]   word1_q;
  logic                refilled_q;
  logic [CNT_W-1:0]    hit_cnt_q;
  logic [CNT_W-1:0]    miss_cnt_q;

  // refilled_q marks the re-lookup after a WRITE so it neither counts nor refills again
  always_ff @(posedge w_clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state      <= ST_IDLE;
      a_q        <= '0;
      word0_q    <= '0;
      word1_q    <= '0;
      refilled_q <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (w_req) begin
            a_q        <= w_addr;
            refilled_q <= 1'b0;
            state      <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (w_c_hit) begin
            if (!refilled_q && (hit_cnt_q != '1)) hit_cnt_q <= hit_cnt_q + CNT_W'(1);
            state <= ST_IDLE;
          end else if (refilled_q) begin
            state <= ST_IDLE;
          end else begin
            if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
            state <= ST_FILL0;
          end
        end
        ST_FILL0: begin
          if (w_mem_ack) begin
            word0_q <= w_mem_data;
            state   <= ST_FILL1;
          end
        end
        ST_FILL1: begin
          if (w_mem_ack) begin
            word1_q <= w_mem_data;
            state   <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          refilled_q <= 1'b1;
          state      <= ST_LOOKUP;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output decode from registered state; only the hit response follows the cache inputs
  always_comb begin
    w_ready    = 1'b0;
    w_rvalid   = 1'b0;
    w_rdata    = '0;
    w_c_addr   = '0;
    w_c_we     = 1'b0;
    w_c_wa     = '0;
    w_c_wd     = '0;
    w_mem_req  = 1'b0;
    w_mem_addr = '0;
    unique case (state)
      ST_IDLE: w_ready = 1'b1;
      ST_LOOKUP: begin
        w_c_addr = a_q;
        if (w_c_hit) begin
          w_rvalid = 1'b1;
          w_rdata  = w_c_dout;
        end
      end
      ST_FILL0: begin
        w_c_addr   = a_q;
        w_mem_req  = 1'b1;
        w_mem_addr = {a_q[31:3], 3'b000};
      end
      ST_FILL1: begin
        w_c_addr   = a_q;
        w_mem_req  = 1'b1;
        w_mem_addr = {a_q[31:3], 3'b100};
      end
      ST_WRITE: begin
        w_c_addr = a_q;
        w_c_we   = 1'b1;
        w_c_wa   = a_q[7:3];
        w_c_wd   = {1'b1, a_q[31:8], word1_q, word0_q};
      end
      default: w_ready = 1'b0;
    endcase
  end

  assign w_hit_cnt  = hit_cnt_q;
  assign w_miss_cnt = miss_cnt_q;

endmodule

// File: doc/m_cache_refill_controller.md
M_CACHE_REFILL_CONTROLLER -- requirements
Module: m_cache_refill_controller

Interface
REQ-001 The block SHALL have exactly one clock and one reset: reset is asynchronous and active-low.
REQ-002 The ports SHALL be as follows (name  direction  width  meaning):
- w_clock  in  1  rising-edge clock
- w_rst_n  in  1  asynchronous active-low reset
- w_req  in  1  CPU read request; sampled only when w_ready=1
- w_addr  in  32  CPU byte address, sampled with w_req
- w_ready  out  1  controller idle, able to accept w_req
- w_rvalid  out  1  one-cycle pulse: w_rdata valid
- w_rdata  out  32  read data
- w_c_addr  out  32  lookup address driven to the cache array
- w_c_hit  in  1  cache hit for w_c_addr (combinational)
- w_c_dout  in  32  cache data for w_c_addr (combinational)
- w_c_we  out  1  cache line write enable
- w_c_wa  out  5  cache line index to write
- w_c_wd  out  89  cache line {valid, tag[23:0], word1[31:0], word0[31:0]}
- w_mem_req  out  1  memory word read request, held until acknowledged
- w_mem_addr  out  32  memory word address
- w_mem_ack  in  1  memory data valid on w_mem_data
- w_mem_data  in  32  memory read data
- w_hit_cnt  out  16  saturating hit counter
- w_miss_cnt  out  16  saturating miss counter

Function
REQ-003 The FSM states SHALL be IDLE, LOOKUP, FILL0, FILL1, WRITE.
REQ-004 w_ready SHALL be 1 only in IDLE; in IDLE, w_req=1 latches w_addr into A and moves to LOOKUP.
REQ-005 w_c_addr SHALL equal A in every state other than IDLE, and 0 in IDLE.
REQ-006 LOOKUP, on w_c_hit=1: w_rvalid=1 and w_rdata=w_c_dout in that same cycle; next state IDLE (hit latency 2 cycles from w_req to w_rvalid).
REQ-007 LOOKUP, on w_c_hit=0 after a refill of A: next state IDLE without pulsing w_rvalid; in all other LOOKUP hit=0 cases, next state FILL0.
REQ-008 w_miss_cnt SHALL increment on the LOOKUP→FILL0 transition; w_hit_cnt SHALL increment on a LOOKUP hit whose request has not been refilled.
REQ-009 The counters SHALL saturate at 16'hFFFF.
REQ-010 The post-refill hit SHALL count nothing.
REQ-011 FILL0 SHALL drive w_mem_req=1 and w_mem_addr={A[31:3],3'b000}; on w_mem_ack, capture w_mem_data as word0 and go to FILL1.
REQ-012 FILL1 SHALL drive w_mem_req=1 and w_mem_addr={A[31:3],3'b100}; on w_mem_ack, capture w_mem_data as word1 and go to WRITE.
REQ-013 In either FILL state, the next state SHALL remain unchanged while w_mem_ack=0, with w_mem_req and w_mem_addr held stable.
REQ-014 w_mem_ack SHALL be ignored outside FILL0/FILL1.
REQ-015 WRITE SHALL last exactly one cycle and drive w_c_we=1, w_c_wa=A[7:3], w_c_wd={1'b1, A[31:8], word1, word0}, then go to LOOKUP.
REQ-016 After the WRITE, the re-lookup SHALL hit and return the word selected by A[2] (1→word1, 0→word0).
REQ-017 The miss latency with zero-wait memory SHALL be 6 cycles from w_req to w_rvalid.
REQ-018 w_c_we SHALL be 1 only in WRITE, and w_c_wa and w_c_wd SHALL be 0 outside WRITE.
REQ-019 w_mem_req SHALL be 1 only in FILL0/FILL1, and w_mem_addr SHALL be 0 otherwise.
REQ-020 w_rdata SHALL be 0 whenever w_rvalid=0.
REQ-021 w_req asserted while w_ready=0 SHALL be ignored (no queuing); w_addr changes while busy SHALL NOT affect A.
REQ-022 The controller SHALL be the sole writer of the cache array.
REQ-023 A refill SHALL overwrite the indexed line unconditionally; there is no write-back.

Reset
REQ-024 While w_rst_n=0, the state SHALL be IDLE.
REQ-025 While w_rst_n=0, A, word0, word1 and both counters SHALL be 0.
REQ-026 While w_rst_n=0, every output SHALL be 0 except w_ready=1.
REQ-027 Reset asserted mid-FILL SHALL abandon the refill with no w_c_we pulse; an ack arriving after reset SHALL be ignored.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- Cold miss: cache empty, w_req addr 32'h0000_1234, memory returns 32'hAAAA_0001 at 0x1230 and 32'hBBBB_0002 at 0x1234, zero wait -> w_c_we with w_c_wa=5'h06, w_c_wd={1,24'h000012,BBBB_0002,AAAA_0001}; w_rvalid at cycle 6 with rdata 32'hBBBB_0002; miss_cnt=1.
- Hit: repeat addr 32'h0000_1230 -> w_rvalid at cycle 2, rdata 32'hAAAA_0001, no w_mem_req, hit_cnt=1.
- Conflict: addr 32'h0000_2230 (same index 6, tag 0x22) -> miss, refill overwrites line 6; then 32'h0000_1230 misses again.
- Memory wait: ack delayed 3 cycles in FILL0 -> w_mem_req/w_mem_addr stable 4 cycles; spurious ack in IDLE has no effect.
- Busy request: w_req pulsed during FILL1 with a different address -> ignored, A unchanged, response data for the original address.
- Reset mid-FILL1 -> all outputs 0, w_ready=1, counters 0, no cache write; next request proceeds normally.
- Saturation: force 65536 hits -> w_hit_cnt stays 16'hFFFF.
